// File: rtl/stdp_synapse_array.sv
// -----------------------------------------------------------------------------
// stdp_synapse_array
//
// Learning synapse bank. N_CH presynaptic channels converge on a single
// postsynaptic neuron. Each channel keeps a pre-trace and the neuron shares
// one post-trace. Both kinds of trace decay geometrically. Pair-based STDP
// adapts each weight with saturation. The bank also produces the weighted input
// current for the downstream LIF neuron.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   pre_spike    [N_CH]       presynaptic spikes, one bit per channel
//   post_spike   1            postsynaptic spike (from the LIF spike output)
//   learn_en     1            1: weights adapt, 0: weights frozen
//   weights      [N_CH*W_W]   packed weights, channel i at [i*W_W +: W_W]
//   current_out  [CUR_W]      registered, saturated sum of spiking weights
//   pre_trace    [N_CH*TR_W]  packed pre-traces, channel i at [i*TR_W +: TR_W]
//   post_trace   [TR_W]       shared post-trace
// -----------------------------------------------------------------------------
module stdp_synapse_array #(
  parameter int N_CH        = 4,
  parameter int W_W         = 8,
  parameter int W_MAX       = 127,
  parameter int W_MIN       = 0,
  parameter int W_INIT      = 64,
  parameter int TR_W        = 8,
  parameter int TR_MAX      = 255,
  parameter int DECAY_SHIFT = 3,
  parameter int LTP_SHIFT   = 2,
  parameter int LTD_SHIFT   = 3,
  parameter int CUR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        pre_spike,
  input  logic                   post_spike,
  input  logic                   learn_en,
  output logic [N_CH*W_W-1:0]    weights,
  output logic [CUR_W-1:0]       current_out,
  output logic [N_CH*TR_W-1:0]   pre_trace,
  output logic [TR_W-1:0]        post_trace
);

  // The signed update width is W_W+2 bits. It is widened further when the
  // trace is wider than the weight, so that a large LTP step cannot wrap.
  localparam int UPD_W = ((W_W > TR_W) ? W_W : TR_W) + 2;
  localparam int ACC_W = W_W + $clog2(N_CH) + 1;

  localparam logic [TR_W-1:0]         TR_LOAD  = TR_W'(TR_MAX);
  localparam logic [W_W-1:0]          W_RST    = W_W'(W_INIT);
  localparam logic [W_W-1:0]          W_HI     = W_W'(W_MAX);
  localparam logic [W_W-1:0]          W_LO     = W_W'(W_MIN);
  localparam logic signed [UPD_W-1:0] W_MAX_S  = UPD_W'(W_MAX);
  localparam logic signed [UPD_W-1:0] W_MIN_S  = UPD_W'(W_MIN);
  localparam logic [31:0]             CUR_MAX  = 32'((64'(1) << CUR_W) - 64'(1));

  logic [W_W-1:0]   w_q      [N_CH];
  logic [W_W-1:0]   w_d      [N_CH];
  logic [TR_W-1:0]  pre_tr_q [N_CH];
  logic [TR_W-1:0]  pre_tr_d [N_CH];
  logic [TR_W-1:0]  post_tr_q, post_tr_d;
  logic [CUR_W-1:0] cur_q, cur_d;
  logic [ACC_W-1:0] acc;

  // Geometric decay. The step never falls below 1, so a trace that is not
  // refreshed always reaches zero in a bounded number of cycles.
  function automatic logic [TR_W-1:0] decay(input logic [TR_W-1:0] tr);
    logic [TR_W-1:0] step;
    step = tr >> DECAY_SHIFT;
    if (step == '0) step = TR_W'(1);
    return (tr == '0) ? '0 : tr - step;
  endfunction

  // Next-state logic. Every term reads only registered values, so LTP, LTD
  // and the current sum all use the traces and weights from before the edge.
  always_comb begin
    // NOTE: every comb output gets a default before any branch; otherwise a
    // path that skips the assignment infers a latch.
    post_tr_d = post_spike ? TR_LOAD : decay(post_tr_q);
    acc       = '0;
    cur_d     = '0;

    for (int i = 0; i < N_CH; i++) begin
      logic signed [UPD_W-1:0] ltp;
      logic signed [UPD_W-1:0] ltd;
      logic signed [UPD_W-1:0] sum;
      ltp = '0;
      ltd = '0;
      sum = '0;

      pre_tr_d[i] = pre_spike[i] ? TR_LOAD : decay(pre_tr_q[i]);
      w_d[i]      = w_q[i];

      if (learn_en) begin
        if (post_spike)   ltp = UPD_W'(pre_tr_q[i] >> LTP_SHIFT);
        if (pre_spike[i]) ltd = UPD_W'(post_tr_q >> LTD_SHIFT);
        sum = $signed(UPD_W'(w_q[i])) + ltp - ltd;
        if (sum < W_MIN_S)      w_d[i] = W_LO;
        else if (sum > W_MAX_S) w_d[i] = W_HI;
        else                    w_d[i] = sum[W_W-1:0];
      end

      if (pre_spike[i]) acc = acc + ACC_W'(w_q[i]);
    end

    if (32'(acc) > CUR_MAX) cur_d = CUR_W'(CUR_MAX);
    else                    cur_d = CUR_W'(acc);
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples pre-edge values whatever order the updates appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the weight array is a small register bank, not RAM. Reset reaches
      // every entry so that learning restarts from W_INIT.
      for (int i = 0; i < N_CH; i++) begin
        w_q[i]      <= W_RST;
        pre_tr_q[i] <= '0;
      end
      post_tr_q <= '0;
      cur_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        w_q[i]      <= w_d[i];
        pre_tr_q[i] <= pre_tr_d[i];
      end
      post_tr_q <= post_tr_d;
      cur_q     <= cur_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign weights[g*W_W +: W_W]    = w_q[g];
    assign pre_trace[g*TR_W +: TR_W] = pre_tr_q[g];
  end

  assign post_trace  = post_tr_q;
  assign current_out = cur_q;

endmodule
